// File: rtl/dds_mix_gen.sv
// Multi-channel DDS generator/mixer: per-channel phase accumulator, wave shaper, gain, summed output.
// Optional per-channel phase offset enabled by defining PHASE_OFFSET_EN.
module dds_mix_gen #(
   parameter int unsigned NCH = 2,
   parameter int unsigned DW  = 8,
   parameter int unsigned PW  = 16,
   parameter int unsigned GW  = 8,
   localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int unsigned SW = $clog2(NCH),
   localparam int unsigned OW = DW + SW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          sync_clr,
   input  logic          cfg_we,
   input  logic [CW-1:0] cfg_ch,
   input  logic [1:0]    cfg_addr,
   input  logic [PW-1:0] cfg_wdata,
   output logic [OW-1:0] dout,
   output logic          dout_valid
);

   localparam logic [GW:0] GAIN_ONE = {1'b1, {GW{1'b0}}};

   logic [PW-1:0] acc_q    [NCH];
   logic [PW-1:0] ftw_q    [NCH];
   logic [1:0]    mode_q   [NCH];
   logic [GW:0]   gain_q   [NCH];
   logic [DW-1:0] wave_q   [NCH];
   logic [DW-1:0] scaled_q [NCH];
   logic [PW-1:0] phase    [NCH];
   logic [DW-1:0] wave_d   [NCH];
   logic [DW-1:0] scaled_d [NCH];
   logic [OW-1:0] sum_d;
   logic [OW-1:0] dout_q;
   logic [2:0]    vld_q;

   // Parabolic sine approximation plus the three piecewise-linear shapes.
   function automatic logic [DW-1:0] wave_lut(input logic [1:0] mode, input logic [DW-1:0] x);
      logic [DW-2:0]   h;
      logic [DW-2:0]   hn;
      logic [2*DW-3:0] prod;
      logic [2*DW-3:0] lim;
      logic [DW-1:0]   m;
      logic [DW-1:0]   half;
      logic [DW-1:0]   tri_up;
      h      = x[DW-2:0];
      hn     = ~h;
      prod   = {{(DW-1){1'b0}}, h} * {{(DW-1){1'b0}}, hn};
      prod   = prod >> (DW - 3);
      lim    = {{(DW-1){1'b0}}, {(DW-1){1'b1}}};
      m      = (prod > lim) ? lim[DW-1:0] : prod[DW-1:0];
      half   = {1'b1, {(DW-1){1'b0}}};
      tri_up = {h, 1'b0};
      case (mode)
         2'd0:    wave_lut = x[DW-1] ? (~half - m) : (half + m);
         2'd1:    wave_lut = x[DW-1] ? '0 : '1;
         2'd2:    wave_lut = x;
         default: wave_lut = x[DW-1] ? ~tri_up : tri_up;
      endcase
   endfunction

`ifdef PHASE_OFFSET_EN
   logic [PW-1:0] off_q [NCH];

   // Offset survives sync_clr so a channel's relative phase is preserved across restarts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) off_q[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (cfg_we && cfg_ch == CW'(i) && cfg_addr == 2'd3) off_q[i] <= cfg_wdata;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) phase[i] = acc_q[i] + off_q[i];
   end
`else
   always_comb begin
      for (int i = 0; i < NCH; i++) phase[i] = acc_q[i];
   end
`endif

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         wave_d[i] = wave_lut(mode_q[i], DW'(phase[i] >> (PW - DW)));
      end
   end

   // Gains above unity are clamped rather than wrapped.
   always_comb begin
      logic [DW+GW:0] prod_g;
      logic [DW+GW:0] shifted;
      for (int i = 0; i < NCH; i++) begin
         prod_g      = {{(GW+1){1'b0}}, wave_q[i]} * {{DW{1'b0}}, gain_q[i]};
         shifted     = prod_g >> GW;
         scaled_d[i] = (|shifted[DW+GW:DW]) ? '1 : shifted[DW-1:0];
      end
   end

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < NCH; i++) sum_d = sum_d + OW'(scaled_q[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            acc_q[i]    <= '0;
            ftw_q[i]    <= '0;
            mode_q[i]   <= '0;
            gain_q[i]   <= GAIN_ONE;
            wave_q[i]   <= '0;
            scaled_q[i] <= '0;
         end
         dout_q <= '0;
         vld_q  <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (cfg_we && cfg_ch == CW'(i)) begin
               case (cfg_addr)
                  2'd0:    mode_q[i] <= cfg_wdata[1:0];
                  2'd1:    ftw_q[i]  <= cfg_wdata;
                  2'd2:    gain_q[i] <= cfg_wdata[GW:0];
                  default: ;
               endcase
            end
            if (sync_clr) begin
               acc_q[i] <= '0;
            end else if (en) begin
               acc_q[i] <= acc_q[i] + ftw_q[i];
            end
            wave_q[i]   <= wave_d[i];
            scaled_q[i] <= scaled_d[i];
         end
         dout_q <= sum_d;
         vld_q  <= {vld_q[1:0], en};
      end
   end

   assign dout       = dout_q;
   assign dout_valid = vld_q[2];

endmodule

// File: tb/tb_dds_mix_gen.sv
// Directed bench for dds_mix_gen at NCH=2, DW=8, PW=16, GW=8.
// Offset checks follow PHASE_OFFSET_EN as defined for the build.
module tb_dds_mix_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        sync_clr;
   logic        cfg_we;
   logic [0:0]  cfg_ch;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic [8:0]  dout;
   logic        dout_valid;

   int checks = 0;
   int errors = 0;

   dds_mix_gen #(.NCH(2), .DW(8), .PW(16), .GW(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .sync_clr   (sync_clr),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .dout       (dout),
      .dout_valid (dout_valid)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_wr(input logic ch, input logic [1:0] a, input logic [15:0] d);
      cfg_ch    = ch;
      cfg_addr  = a;
      cfg_wdata = d;
      cfg_we    = 1'b1;
      step();
      cfg_we    = 1'b0;
   endtask

   // Stop, configure ch0 (ch1 silenced), clear phase and let the pipe settle on acc=0.
   task automatic prep(input logic [1:0] mode, input logic [15:0] ftw, input logic [15:0] gain);
      en = 1'b0;
      cfg_wr(1'b0, 2'd0, {14'd0, mode});
      cfg_wr(1'b0, 2'd1, ftw);
      cfg_wr(1'b0, 2'd2, gain);
      cfg_wr(1'b1, 2'd2, 16'd0);
      sync_clr = 1'b1;
      step();
      sync_clr = 1'b0;
      repeat (4) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; sync_clr = 1'b0; cfg_we = 1'b0;
      cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
      #2;
      repeat (2) begin
         checks++;
         if (dout !== 9'd0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: dout=%0d valid=%b, expected 0/0", dout, dout_valid);
         end
         step();
      end
      rst_n = 1'b1;
      step(); step();
      checks++;
      if (dout !== 9'd0 || dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_lat2: dout=%0d valid=%b, expected 0/0", dout, dout_valid);
      end
      step();
      checks++;
      if (dout !== 9'd256 || dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_sine0: dout=%0d valid=%b, expected 256/1", dout, dout_valid);
      end
   endtask

   task automatic test_saw();
      int idx;
      logic [8:0] exp_d;
      prep(2'd2, 16'h0100, 16'h0100);
      en = 1'b1;
      for (int j = 1; j <= 300; j++) begin
         step();
         idx   = (j > 3) ? j - 3 : 0;
         exp_d = 9'(idx % 256);
         checks++;
         if (dout !== exp_d || dout_valid !== (j >= 3)) begin
            errors++;
            $display("FAIL saw j=%0d: dout=%0d valid=%b, expected %0d/%b",
                     j, dout, dout_valid, exp_d, (j >= 3));
         end
      end
   endtask

   task automatic test_square();
      int idx;
      logic [8:0] exp_d;
      prep(2'd1, 16'h0100, 16'h0100);
      en = 1'b1;
      for (int j = 1; j <= 520; j++) begin
         step();
         idx   = (j > 3) ? j - 3 : 0;
         exp_d = ((idx % 256) < 128) ? 9'd255 : 9'd0;
         checks++;
         if (dout !== exp_d) begin
            errors++;
            $display("FAIL square j=%0d: dout=%0d expected %0d", j, dout, exp_d);
         end
      end
   endtask

   task automatic test_half_gain();
      int idx;
      logic [8:0] exp_d;
      prep(2'd2, 16'h0100, 16'h0080);
      en = 1'b1;
      for (int j = 1; j <= 262; j++) begin
         step();
         idx   = (j > 3) ? j - 3 : 0;
         exp_d = 9'((idx % 256) / 2);
         checks++;
         if (dout !== exp_d) begin
            errors++;
            $display("FAIL half_gain j=%0d: dout=%0d expected %0d", j, dout, exp_d);
         end
      end
   endtask

   task automatic test_shapes();
      logic [8:0] sine_t [4];
      logic [8:0] tri_t  [4];
      int idx;
      sine_t[0] = 9'd128; sine_t[1] = 9'd254; sine_t[2] = 9'd127; sine_t[3] = 9'd1;
      tri_t[0]  = 9'd0;   tri_t[1]  = 9'd128; tri_t[2]  = 9'd255; tri_t[3]  = 9'd127;
      prep(2'd0, 16'h4000, 16'h0100);
      en = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         step();
         idx = (j > 3) ? j - 3 : 0;
         checks++;
         if (dout !== sine_t[idx % 4]) begin
            errors++;
            $display("FAIL sine j=%0d: dout=%0d expected %0d", j, dout, sine_t[idx % 4]);
         end
      end
      prep(2'd3, 16'h4000, 16'h0100);
      en = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         step();
         idx = (j > 3) ? j - 3 : 0;
         checks++;
         if (dout !== tri_t[idx % 4]) begin
            errors++;
            $display("FAIL triangle j=%0d: dout=%0d expected %0d", j, dout, tri_t[idx % 4]);
         end
      end
   endtask

   // Leaves ch0 running with acc = 20*0x200 for the en-low test that follows.
   task automatic test_clr_with_cfg();
      prep(2'd2, 16'h0100, 16'h0100);
      en = 1'b1;
      repeat (10) step();
      sync_clr = 1'b1;
      cfg_wr(1'b0, 2'd1, 16'h0200);
      sync_clr = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k >= 3) begin
            checks++;
            if (dout !== 9'(2 * (k - 3))) begin
               errors++;
               $display("FAIL clr_cfg k=%0d: dout=%0d expected %0d", k, dout, 2 * (k - 3));
            end
         end
      end
   endtask

   task automatic test_en_low();
      logic [8:0] exp_d;
      en = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         exp_d = (k == 1) ? 9'd36 : (k == 2) ? 9'd38 : 9'd40;
         checks++;
         if (dout !== exp_d || dout_valid !== (k < 3)) begin
            errors++;
            $display("FAIL en_low k=%0d: dout=%0d valid=%b, expected %0d/%b",
                     k, dout, dout_valid, exp_d, (k < 3));
         end
      end
   endtask

   task automatic test_offset();
      logic [8:0] exp_d;
`ifdef PHASE_OFFSET_EN
      exp_d = 9'd128;
`else
      exp_d = 9'd0;
`endif
      prep(2'd2, 16'h0000, 16'h0100);
      cfg_wr(1'b0, 2'd3, 16'h8000);
      repeat (4) step();
      checks++;
      if (dout !== exp_d) begin
         errors++;
         $display("FAIL offset: dout=%0d expected %0d", dout, exp_d);
      end
      // Offset is not cleared by sync_clr.
      sync_clr = 1'b1;
      step();
      sync_clr = 1'b0;
      repeat (4) step();
      checks++;
      if (dout !== exp_d) begin
         errors++;
         $display("FAIL offset_after_clr: dout=%0d expected %0d", dout, exp_d);
      end
   endtask

   task automatic test_async_reset();
      prep(2'd2, 16'h0100, 16'h0100);
      en = 1'b1;
      repeat (20) step();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dout !== 9'd0 || dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: dout=%0d valid=%b, expected 0/0", dout, dout_valid);
      end
      step();
      rst_n = 1'b1;
      repeat (3) step();
      checks++;
      if (dout !== 9'd256 || dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_defaults: dout=%0d valid=%b, expected 256/1", dout, dout_valid);
      end
   endtask

   initial begin
      test_reset();
      test_saw();
      test_square();
      test_half_gain();
      test_shapes();
      test_clr_with_cfg();
      test_en_low();
      test_offset();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
